// File: rtl/nibble_bank_reader_if.sv
// nibble_bank_reader_if: start/bank/valid-ready stream bundle between the bank reader and its neighbours
interface nibble_bank_reader_if #(
    parameter int N = 8
);
    logic           start;
    logic [4*N-1:0] bank;
    logic           ready;
    logic [3:0]     data;
    logic           valid;
    logic           last;
    logic           busy;
    logic           done;
    modport master (output start, bank, ready, input data, valid, last, busy, done);
    modport slave  (input start, bank, ready, output data, valid, last, busy, done);
endinterface

// File: rtl/nibble_bank_reader.sv
// nibble_bank_reader: snapshots a bank of N nibbles on start and streams them out entry 0 first
module nibble_bank_reader #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input logic clk,
    input logic rst,
    nibble_bank_reader_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [3:0] shadow [N];
    logic done_q, done_n, load, fire, valid, last;
    assign valid = state == SEND;
    assign last = valid && idx == IW'(N - 1);
    assign bus.valid = valid;
    assign bus.busy = valid;
    assign bus.last = last;
    assign bus.data = valid ? shadow[idx] : 4'h0;
    assign bus.done = done_q;
    always_comb begin
        fire = valid && bus.ready;
        load = state == IDLE && bus.start;
        state_n = load ? SEND : (fire && last) ? IDLE : state;
        idx_n = load ? '0 : fire ? (last ? '0 : idx + IW'(1)) : idx;
        done_n = fire && last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < N; i++) shadow[i] <= 4'h0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            done_q <= done_n;
            if (load)
                for (int i = 0; i < N; i++) shadow[i] <= bus.bank[4*i +: 4];
        end
    end
endmodule

// File: tb/tb_nibble_bank_reader.sv
// tb_nibble_bank_reader: randomized stimulus, queue-based reference model and scoreboard monitor
module tb_nibble_bank_reader;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int npass = 0, ntot = 0;
    logic armed = 1'b0, model_busy = 1'b0, exp_done = 1'b0;
    logic [4:0] q[$];
    int done_cnt = 0, exp_readouts = 0;

    nibble_bank_reader_if #(.N(N)) bus ();
    nibble_bank_reader #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Inputs are stable at the falling edge, so the model decides here what the next rising edge does.
    always @(negedge clk) begin
        if (armed) begin
            chk("valid", {31'd0, bus.valid}, {31'd0, model_busy});
            chk("busy", {31'd0, bus.busy}, {31'd0, model_busy});
            chk("done", {31'd0, bus.done}, {31'd0, exp_done});
            if (model_busy && q.size() > 0) begin
                chk("data", {28'd0, bus.data}, {28'd0, q[0][3:0]});
                chk("last", {31'd0, bus.last}, {31'd0, q[0][4]});
            end else begin
                chk("idle_data", {28'd0, bus.data}, 32'd0);
                chk("idle_last", {31'd0, bus.last}, 32'd0);
            end
            if (bus.done === 1'b1) done_cnt++;
        end
        if (rst) begin
            armed = 1'b1;
            q.delete();
            model_busy = 1'b0;
            exp_done = 1'b0;
        end else if (armed) begin
            exp_done = 1'b0;
            if (model_busy && bus.ready && q.size() > 0) begin
                if (q.pop_front()[4]) begin
                    model_busy = 1'b0;
                    exp_done = 1'b1;
                    exp_readouts++;
                end
            end else if (!model_busy && bus.start) begin
                for (int i = 0; i < N; i++) q.push_back({i == N - 1, bus.bank[4*i +: 4]});
                model_busy = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((model_busy || exp_done) && k < 300) begin
            cyc(1);
            k++;
        end
        if (k >= 300) begin
            ntot++;
            $display("FAIL wait_idle: readout still running after %0d cycles", k);
        end
        cyc(2);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bank = '0;
        bus.ready = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(5);
        bus.bank = 32'h76543210;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_idle();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.ready = (i % 3) == 0;
            cyc(1);
        end
        bus.ready = 1'b1;
        wait_idle();
        bus.bank = 32'hFEDCBA98;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(3);
        bus.bank = '0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_idle();
        bus.bank = 32'hCAFE5A5A;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(3);
        rst = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.start = 1'b0;
        cyc(2);
        bus.bank = 32'h11111111;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_idle();
        bus.bank = 32'h0F1E2D3C;
        bus.start = 1'b1;
        cyc(30);
        bus.start = 1'b0;
        wait_idle();
        for (int i = 0; i < 500; i++) begin
            bus.ready = $urandom_range(0, 3) != 0;
            bus.start = $urandom_range(0, 5) == 0;
            bus.bank = $urandom;
            rst = $urandom_range(0, 149) == 0;
            cyc(1);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b1;
        wait_idle();
        chk("queue_empty", q.size(), 32'd0);
        chk("done_count", done_cnt, exp_readouts);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
